// File: rtl/time_keeper_set.sv
// BCD 24-hour time-of-day keeper with a 1 Hz prescaler, set buttons and a free-running
// debounce strobe for the button debouncers.
module time_keeper_set #(
  parameter int unsigned CLK_HZ  = 31500000,
  parameter int unsigned DEB_DIV = 157500
) (
  input  logic       regular_clk,
  input  logic       reset_n,
  input  logic       inc_hours,
  input  logic       inc_minutes,
  input  logic       clr_seconds,
  output logic       deb_tick,
  output logic       sec_tick,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units
);

  localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DebW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_HZ - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_DIV - 1);

  // Returns {carry, tens, units} for a 00-59 BCD field.
  function automatic logic [7:0] inc_base60(input logic [2:0] tens, input logic [3:0] units);
    logic [7:0] r;
    if (units != 4'd9) begin
      r = {1'b0, tens, units + 4'd1};
    end else if (tens != 3'd5) begin
      r = {1'b0, tens + 3'd1, 4'd0};
    end else begin
      r = {1'b1, 3'd0, 4'd0};
    end
    return r;
  endfunction

  function automatic logic [5:0] inc_hours24(input logic [1:0] tens, input logic [3:0] units);
    logic [5:0] r;
    if (tens == 2'd2 && units == 4'd3) begin
      r = '0;
    end else if (units == 4'd9) begin
      r = {tens + 2'd1, 4'd0};
    end else begin
      r = {tens, units + 4'd1};
    end
    return r;
  endfunction

  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic            deb_tick_q, deb_tick_d;
  logic            sec_tick_q, sec_tick_d;
  logic            pend_q, pend_d;
  logic [1:0]      hr_tens_q, hr_tens_d;
  logic [3:0]      hr_units_q, hr_units_d;
  logic [2:0]      min_tens_q, min_tens_d;
  logic [3:0]      min_units_q, min_units_d;
  logic [2:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      sec_units_q, sec_units_d;

  logic            raw_tick;
  logic [7:0]      sec_nxt, min_nxt;
  logic [5:0]      hr_nxt;

  assign raw_tick = (pre_cnt_q == PreLast);
  assign sec_nxt  = inc_base60(sec_tens_q, sec_units_q);
  assign min_nxt  = inc_base60(min_tens_q, min_units_q);
  assign hr_nxt   = inc_hours24(hr_tens_q, hr_units_q);

  always_comb begin
    deb_cnt_d  = (deb_cnt_q == DebLast) ? '0 : deb_cnt_q + DebW'(1);
    deb_tick_d = (deb_cnt_q == DebLast);
    pre_cnt_d  = (clr_seconds || raw_tick) ? '0 : pre_cnt_q + PreW'(1);
  end

  always_comb begin
    hr_tens_d   = hr_tens_q;
    hr_units_d  = hr_units_q;
    min_tens_d  = min_tens_q;
    min_units_d = min_units_q;
    sec_tens_d  = sec_tens_q;
    sec_units_d = sec_units_q;
    pend_d      = pend_q;
    sec_tick_d  = 1'b0;
    if (clr_seconds) begin
      sec_tens_d  = 3'd0;
      sec_units_d = 4'd0;
      pend_d      = 1'b0;
    end else if (inc_hours || inc_minutes) begin
      // Set buttons never carry; a coinciding second is deferred by one cycle.
      if (inc_hours) {hr_tens_d, hr_units_d} = hr_nxt;
      if (inc_minutes) {min_tens_d, min_units_d} = min_nxt[6:0];
      if (raw_tick) pend_d = 1'b1;
    end else if (raw_tick || pend_q) begin
      pend_d                    = 1'b0;
      sec_tick_d                = 1'b1;
      {sec_tens_d, sec_units_d} = sec_nxt[6:0];
      if (sec_nxt[7]) begin
        {min_tens_d, min_units_d} = min_nxt[6:0];
        if (min_nxt[7]) {hr_tens_d, hr_units_d} = hr_nxt;
      end
    end
  end

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      deb_tick_q  <= 1'b0;
      sec_tick_q  <= 1'b0;
      pend_q      <= 1'b0;
      hr_tens_q   <= '0;
      hr_units_q  <= '0;
      min_tens_q  <= '0;
      min_units_q <= '0;
      sec_tens_q  <= '0;
      sec_units_q <= '0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      deb_tick_q  <= deb_tick_d;
      sec_tick_q  <= sec_tick_d;
      pend_q      <= pend_d;
      hr_tens_q   <= hr_tens_d;
      hr_units_q  <= hr_units_d;
      min_tens_q  <= min_tens_d;
      min_units_q <= min_units_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
    end
  end

  assign deb_tick  = deb_tick_q;
  assign sec_tick  = sec_tick_q;
  assign hr_tens   = hr_tens_q;
  assign hr_units  = hr_units_q;
  assign min_tens  = min_tens_q;
  assign min_units = min_units_q;
  assign sec_tens  = sec_tens_q;
  assign sec_units = sec_units_q;

endmodule

// File: doc/time_keeper_set.md
Name: time_keeper_set

Overview:
- Downstream consumer of the per-button debouncer pulses in the VGA clock.
- Keeps the time of day as BCD HH:MM:SS (24 h), advanced by an internal 1 Hz prescaler.
- Applies single-cycle set pulses from the hour, minute and second buttons.
- Also generates the slow debounce strobe that feeds the debouncers' slow_clk, and drives the digit renderer.

Parameters:
- CLK_HZ, 31500000: regular_clk frequency; the 1 Hz prescaler divides by this value.
- DEB_DIV, 157500: debounce strobe period in clocks (5 ms at 31.5 MHz).

Ports:
- regular_clk  input  1  system clock, 31.5 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- inc_hours  input  1  single-cycle pulse from the hour debouncer.
- inc_minutes  input  1  single-cycle pulse from the minute debouncer.
- clr_seconds  input  1  single-cycle pulse: zero seconds and resynchronise the prescaler.
- deb_tick  output  1  one-cycle strobe every DEB_DIV clocks; drives the debouncers' slow_clk.
- sec_tick  output  1  one-cycle strobe on each applied 1 s advance.
- hr_tens  output  2  hours tens digit, 0-2.
- hr_units  output  4  hours units digit, 0-9.
- min_tens  output  3  minutes tens digit, 0-5.
- min_units  output  4  minutes units digit, 0-9.
- sec_tens  output  3  seconds tens digit, 0-5.
- sec_units  output  4  seconds units digit, 0-9.

Behaviour:
- Interface: one clock, regular_clk. Reset reset_n is asynchronous and active-low.
- Reset:
  - All digits are 0 (00:00:00). deb_tick = 0, sec_tick = 0.
  - Both prescaler counters are 0; tick_pending = 0.
- Debounce divider:
  - Counter width is $clog2(DEB_DIV).
  - deb_tick is registered and high for exactly one cycle when the counter equals DEB_DIV-1; the counter then wraps to 0.
  - First deb_tick appears DEB_DIV cycles after reset release. It is free-running and unaffected by the buttons.
- 1 Hz prescaler:
  - Counter width is $clog2(CLK_HZ). It raises raw_tick for one cycle at CLK_HZ-1, then wraps to 0.
  - clr_seconds forces the counter to 0 that cycle, so the next raw_tick is CLK_HZ cycles later.
- Update priority per cycle (exactly one action):
  - 1. clr_seconds: sec_tens/sec_units = 0. Minutes and hours are unchanged. Any raw_tick or tick_pending is discarded.
  - 2. Else inc_hours or inc_minutes (both may be high in the same cycle):
    - Hours +1, wrapping 23 -> 00.
    - Minutes +1, wrapping 59 -> 00 with no carry into hours.
    - If raw_tick is high that cycle, set tick_pending = 1 instead of advancing the seconds.
  - 3. Else if raw_tick or tick_pending: advance 1 s, clear tick_pending, and pulse sec_tick (registered, same cycle as the digit update).
- 1 s advance carry chain:
  - sec_units 9 -> 0 carries into sec_tens; sec_tens 5 -> 0 carries into min_units.
  - Minutes carry the same way; 59 min carries into hours.
  - Hours BCD wrap: 09 -> 10, 19 -> 20, 23 -> 00.
- tick_pending holds at most one tick. A raw_tick that coincides with a pending tick and no button both set and clear it in the same cycle, so the net effect is one advance (cannot occur in practice, since CLK_HZ >> 2).
- Output encoding: outputs are registered and always valid BCD. Values outside the legal digit ranges are never produced.
- Reset mid-operation: reset_n low asynchronously returns everything to the reset state, including a pending tick. No sec_tick fires on reset release.

Test Plan:
- Free run: CLK_HZ=10, DEB_DIV=4, no buttons, 10 s simulated.
  - sec_tick every 10 clocks; digits reach 00:00:10.
  - deb_tick every 4 clocks; first deb_tick at cycle 4 after reset release.
- Rollover: preload to 23:59:59 via 23 inc_hours and 59 inc_minutes pulses plus clock ticks.
  - Next raw_tick -> 00:00:00; sec_tick high that cycle.
- Wrap without carry: minutes at 59, inc_minutes -> minutes 00, hours unchanged.
  - Hours at 23, inc_hours -> 00.
- Collision: inc_minutes in the same cycle as raw_tick at 12:34:56.
  - That cycle -> 12:35:56; next cycle -> 12:35:57, with sec_tick only on the second cycle.
- Clear: clr_seconds at 08:15:42 with raw_tick coincident.
  - -> 08:15:00, no sec_tick; next sec_tick exactly CLK_HZ cycles later.
- Async reset: drop reset_n between clock edges while tick_pending = 1.
  - Outputs go to 00:00:00 immediately.
  - No sec_tick after release until CLK_HZ cycles elapse.
